// File: rtl/fmul_arbiter_if.sv
// Bundle between the FPU issue ports, the shared-multiplier arbiter and the fmul core.
// Requester side and multiplier side travel together so one port carries the whole datapath.
interface fmul_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_x1;
  logic [32*NUM_REQ-1:0] req_x2;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [31:0]           resp_y;
  logic [31:0]           mul_x1;
  logic [31:0]           mul_x2;
  logic                  mul_ready;
  logic                  mul_valid;
  logic [31:0]           mul_y;

  // Arbiter view.
  modport slave (
    input  req_valid, req_x1, req_x2, resp_ready, mul_valid, mul_y,
    output req_ready, resp_valid, resp_y, mul_x1, mul_x2, mul_ready
  );

  // Environment view: requesters plus the fmul core.
  modport master (
    output req_valid, req_x1, req_x2, resp_ready, mul_valid, mul_y,
    input  req_ready, resp_valid, resp_y, mul_x1, mul_x2, mul_ready
  );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one fmul between NUM_REQ requesters.
// Operands stay registered for the whole multiply; the product is held until the owner takes it.
module fmul_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  fmul_arbiter_if.slave bus,
  output logic          busy
);
  localparam int unsigned LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          r_state, w_state_d;
  logic [LW-1:0]   r_last, w_last_d;
  logic [LW-1:0]   r_owner, w_owner_d;
  logic [31:0]     r_op1, w_op1_d;
  logic [31:0]     r_op2, w_op2_d;
  logic [31:0]     r_res, w_res_d;

  logic            w_found;
  logic [LW-1:0]   w_win;
  logic [LW-1:0]   w_idx;
  logic [31:0]     w_x1 [NUM_REQ];
  logic [31:0]     w_x2 [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_x1[g] = bus.req_x1[32*g +: 32];
    assign w_x2[g] = bus.req_x2[32*g +: 32];
  end

  // First valid requester scanning upward from last+1, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = LW'((32'(r_last) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_last_d       = r_last;
    w_owner_d      = r_owner;
    w_op1_d        = r_op1;
    w_op2_d        = r_op2;
    w_res_d        = r_res;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.mul_ready  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!rst && w_found) begin
          bus.req_ready = NUM_REQ'(1) << w_win;
          w_state_d     = StIssue;
          w_last_d      = w_win;
          w_owner_d     = w_win;
          w_op1_d       = w_x1[w_win];
          w_op2_d       = w_x2[w_win];
        end
      end
      StIssue: begin
        bus.mul_ready = 1'b1;
        w_state_d     = StWait;
      end
      StWait: begin
        if (bus.mul_valid) begin
          w_res_d   = bus.mul_y;
          w_state_d = StResp;
        end
      end
      StResp: begin
        bus.resp_valid = NUM_REQ'(1) << r_owner;
        if (bus.resp_ready[r_owner]) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_last  <= LW'(NUM_REQ - 1);
      r_owner <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
      r_owner <= w_owner_d;
      r_op1   <= w_op1_d;
      r_op2   <= w_op2_d;
      r_res   <= w_res_d;
    end
  end

  // fmul evaluates its exponent path combinationally, so operands come straight from registers.
  assign bus.mul_x1 = r_op1;
  assign bus.mul_x2 = r_op2;
  assign bus.resp_y = r_res;
  assign busy       = (r_state != StIdle);
endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter with two requesters: transaction-level reference model,
// an fmul stand-in with one-cycle response and stray mul_valid pulses.
module tb_fmul_arbiter;
  localparam int unsigned N = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  fmul_arbiter_if #(.NUM_REQ(N)) bus ();

  fmul_arbiter #(.NUM_REQ(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pending operand pairs per requester, {x1, x2}.
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  // Reference model: cycles since accept (0 when idle), owner, last winner, operands, result.
  int          m_cyc   = 0;
  int          m_owner = 0;
  int          m_last  = N - 1;
  logic [31:0] m_op1   = '0;
  logic [31:0] m_op2   = '0;
  logic [31:0] m_res   = '0;

  logic [1:0]  rr        = 2'b11;
  logic        glitch_en = 1'b0;
  logic        stale     = 1'b0;

  int          grant_log[$];
  logic [31:0] resp_log[$];
  int          n_resp   = 0;
  int          n_pushed = 0;

  // Stand-in for fmul: a few exact IEEE products, a fixed scramble elsewhere.
  function automatic logic [31:0] fref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] k;
    k = {a, b};
    case (k)
      64'h40000000_40400000: return 32'h40C00000;
      64'h3FC00000_3FC00000: return 32'h40100000;
      64'hC0000000_40400000: return 32'hC0C00000;
      64'h00000000_40400000: return 32'h00000000;
      64'h80000000_40400000: return 32'h80000000;
      default:               return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A5A5A;
    endcase
  endfunction

  // Round robin over two: a lone requester wins; with both, the one not served last wins.
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 0) ? 1 : 0;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) q0.push_back({a, b});
    else q1.push_back({a, b});
    n_pushed++;
  endtask

  task automatic drive_reqs();
    bus.req_valid  = {q1.size() != 0, q0.size() != 0};
    bus.req_x1     = {(q1.size() != 0) ? q1[0][63:32] : 32'h0,
                      (q0.size() != 0) ? q0[0][63:32] : 32'h0};
    bus.req_x2     = {(q1.size() != 0) ? q1[0][31:0] : 32'h0,
                      (q0.size() != 0) ? q0[0][31:0] : 32'h0};
    bus.resp_ready = rr;
  endtask

  // One clock: apply inputs, compare every output with the model, advance across the edge.
  task automatic tick();
    int          w;
    logic        pend;
    logic        rst_now;
    logic [31:0] px1;
    logic [31:0] px2;
    logic [63:0] op;
    drive_reqs();
    #1;
    w = (m_cyc == 0 && !rst) ? pick(bus.req_valid, m_last) : -1;
    chk("req_ready", 32'(bus.req_ready), (w >= 0) ? 32'(1 << w) : 32'h0);
    chk("mul_ready", 32'(bus.mul_ready), 32'(m_cyc == 1));
    chk("busy", 32'(busy), 32'(m_cyc != 0));
    chk("resp_valid", 32'(bus.resp_valid), (m_cyc == 3) ? 32'(1 << m_owner) : 32'h0);
    if (m_cyc == 3) chk("resp_y", bus.resp_y, m_res);
    chk("mul_x1", bus.mul_x1, m_op1);
    chk("mul_x2", bus.mul_x2, m_op2);
    if (bus.req_ready != '0) grant_log.push_back((bus.req_ready == 2'b10) ? 1 : 0);
    if (m_cyc == 3 && rr[m_owner]) begin
      resp_log.push_back(bus.resp_y);
      n_resp++;
    end
    pend    = bus.mul_ready;
    px1     = bus.mul_x1;
    px2     = bus.mul_x2;
    rst_now = rst;
    if (rst) begin
      m_cyc = 0; m_last = N - 1; m_owner = 0;
      m_op1 = '0; m_op2 = '0; m_res = '0;
    end else begin
      case (m_cyc)
        0: if (w >= 0) begin
          op      = (w == 0) ? q0.pop_front() : q1.pop_front();
          m_op1   = op[63:32];
          m_op2   = op[31:0];
          m_owner = w;
          m_last  = w;
          m_cyc   = 1;
        end
        1: m_cyc = 2;
        2: begin m_cyc = 3; m_res = fref(m_op1, m_op2); end
        default: if (rr[m_owner]) m_cyc = 0;
      endcase
    end
    @(posedge clk);
    #1;
    bus.mul_valid = (pend && !rst_now) || stale || (glitch_en && $urandom_range(0, 3) == 0);
    bus.mul_y     = (pend && !rst_now) ? fref(px1, px2) : $urandom;
    stale         = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_cyc != 0) && c < budget) begin
      tick();
      c++;
    end
    chk("drain_in_budget", 32'(c < budget), 32'h1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mul_valid = 1'b0;
    bus.mul_y     = '0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Single request from requester 0.
    push(0, 32'h40000000, 32'h40400000);
    grant_log.delete(); resp_log.delete();
    drain(20);
    chk("single_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'h0);
    chk("single_y", (resp_log.size() > 0) ? resp_log[0] : 32'hDEAD, 32'h40C00000);

    // Both valid straight out of reset: requester 0 first.
    rst = 1'b1;
    push(0, 32'h3FC00000, 32'h3FC00000);
    push(1, 32'hC0000000, 32'h40400000);
    tick();
    rst = 1'b0;
    grant_log.delete(); resp_log.delete();
    drain(30);
    chk("simul_y0", (resp_log.size() > 1) ? resp_log[0] : 32'hDEAD, 32'h40100000);
    chk("simul_y1", (resp_log.size() > 1) ? resp_log[1] : 32'hDEAD, 32'hC0C00000);

    // Fairness with random operands and stray mul_valid pulses.
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, $urandom, $urandom);
      push(1, $urandom, $urandom);
    end
    glitch_en = 1'b1;
    drain(100);
    glitch_en = 1'b0;
    chk("fair_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size(); i++) chk("fair_order", 32'(grant_log[i]), 32'(i % 2));

    // Backpressure on requester 0 while requester 1 waits and asserts its own resp_ready.
    pulse_reset();
    rr = 2'b10;
    push(0, $urandom, $urandom);
    push(1, $urandom, $urandom);
    repeat (3) tick();
    repeat (5) tick();
    rr = 2'b11;
    grant_log.delete();
    tick();
    tick();
    chk("bp_next_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'h1);
    drain(20);

    // Signed zeros pass through untouched.
    resp_log.delete();
    push(0, 32'h00000000, 32'h40400000);
    push(0, 32'h80000000, 32'h40400000);
    drain(30);
    chk("zero_pos", (resp_log.size() > 1) ? resp_log[0] : 32'hDEAD, 32'h00000000);
    chk("zero_neg", (resp_log.size() > 1) ? resp_log[1] : 32'hDEAD, 32'h80000000);

    // Reset in WAIT: operation dropped, stale mul_valid afterwards ignored.
    push(1, 32'h12345678, 32'h9ABCDEF0);
    tick();
    tick();
    rst   = 1'b1;
    stale = 1'b1;
    push(0, 32'h40000000, 32'h40400000);
    push(1, 32'hC0000000, 32'h40400000);
    grant_log.delete(); resp_log.delete();
    tick();
    rst = 1'b0;
    drain(30);
    chk("rst_first_grant", 32'(grant_log.size() > 1 ? grant_log[0] : 9), 32'h0);
    chk("rst_second_grant", 32'(grant_log.size() > 1 ? grant_log[1] : 9), 32'h1);
    chk("rst_y0", (resp_log.size() > 1) ? resp_log[0] : 32'hDEAD, 32'h40C00000);
    chk("rst_y1", (resp_log.size() > 1) ? resp_log[1] : 32'hDEAD, 32'hC0C00000);

    // Random traffic, random resp_ready backpressure and stray pulses.
    glitch_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          if (q0.size() < 3) push(0, $urandom, $urandom);
        end else begin
          if (q1.size() < 3) push(1, $urandom, $urandom);
        end
      end
      rr = 2'($urandom);
      tick();
    end
    rr = 2'b11;
    drain(200);
    glitch_en = 1'b0;
    // One request was dropped by the mid-operation reset.
    chk("resp_total", 32'(n_resp), 32'(n_pushed - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
